// File: rtl/qci_table_writer.sv
`default_nettype none
// ============================================================================
// Module      : qci_table_writer
// Description : Decodes Qci configuration frames from AXI-Stream into 95-bit
//               stream-table entries and drives the table write port (A).
// Revision    : 1.0 - initial release
// ============================================================================
module qci_table_writer #(
    parameter logic [15:0] MAGIC  = 16'hC0F1,
    parameter int          ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       cfg_axis_tdata,
    input  logic [7:0]        cfg_axis_tkeep,
    input  logic              cfg_axis_tlast,
    input  logic              cfg_axis_tvalid,
    output logic              cfg_axis_tready,
    output logic              tbl_ena,
    output logic              tbl_wea,
    output logic [ADDR_W-1:0] tbl_addra,
    output logic [94:0]       tbl_dina,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [15:0]       entries_written,
    output logic [7:0]        err_count
);

    localparam int c_SUM_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
    localparam logic [c_SUM_W-1:0] c_DEPTH = c_SUM_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_tready;
    logic                r_ena;
    logic                r_wea;
    logic [ADDR_W-1:0]   r_addra;
    logic [94:0]         r_dina;
    logic                r_done;
    logic                r_err;
    logic [15:0]         r_entries;
    logic [7:0]          r_err_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_remaining;
    logic [63:0]         r_lo;
    logic                r_drop_err;

    logic                w_beat;
    logic [c_SUM_W-1:0]  w_hdr_sum;
    logic                w_hdr_ok;
    logic [7:0]          w_rem_dec;
    logic                w_lo_bad;
    logic                w_hi_bad;

    assign w_beat    = cfg_axis_tvalid & r_tready;
    assign w_hdr_sum = c_SUM_W'(cfg_axis_tdata[16 +: ADDR_W]) + c_SUM_W'(cfg_axis_tdata[31:24]);
    // The range check uses a widened sum so base+N past the table end cannot wrap.
    assign w_hdr_ok  = (cfg_axis_tdata[15:0] == MAGIC) &&
                       (cfg_axis_tdata[31:24] != 8'd0) &&
                       (w_hdr_sum <= c_DEPTH) &&
                       (cfg_axis_tkeep == 8'hFF) &&
                       !cfg_axis_tlast;
    assign w_rem_dec = r_remaining - 8'd1;
    assign w_lo_bad  = (cfg_axis_tkeep != 8'hFF) || cfg_axis_tlast;
    assign w_hi_bad  = (cfg_axis_tkeep[3:0] != 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_tready    <= 1'b0;
            r_ena       <= 1'b0;
            r_wea       <= 1'b0;
            r_addra     <= '0;
            r_dina      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_entries   <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_lo        <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            r_ena    <= 1'b0;
            r_wea    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            if (w_beat) begin
                case (r_state)
                    S_IDLE: begin
                        r_drop_err <= 1'b0;
                        if (w_hdr_ok) begin
                            r_addr      <= cfg_axis_tdata[16 +: ADDR_W];
                            r_remaining <= cfg_axis_tdata[31:24];
                            r_state     <= S_LO;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= cfg_axis_tlast ? S_IDLE : S_DROP;
                        end
                    end
                    S_LO: begin
                        if (w_lo_bad) begin
                            r_err      <= 1'b1;
                            r_drop_err <= 1'b0;
                            r_state    <= cfg_axis_tlast ? S_IDLE : S_DROP;
                        end else begin
                            r_lo    <= cfg_axis_tdata;
                            r_state <= S_HI;
                        end
                    end
                    S_HI: begin
                        if (w_hi_bad) begin
                            r_err      <= 1'b1;
                            r_drop_err <= 1'b0;
                            r_state    <= cfg_axis_tlast ? S_IDLE : S_DROP;
                        end else begin
                            r_ena       <= 1'b1;
                            r_wea       <= 1'b1;
                            r_addra     <= r_addr;
                            r_dina      <= {cfg_axis_tdata[30:0], r_lo};
                            r_addr      <= r_addr + ADDR_W'(1);
                            r_remaining <= w_rem_dec;
                            if (r_entries != 16'hFFFF) begin
                                r_entries <= r_entries + 16'd1;
                            end
                            if (w_rem_dec == 8'd0) begin
                                if (cfg_axis_tlast) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_IDLE;
                                end else begin
                                    // Surplus beats: the error is reported once the frame ends.
                                    r_drop_err <= 1'b1;
                                    r_state    <= S_DROP;
                                end
                            end else if (cfg_axis_tlast) begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_LO;
                            end
                        end
                    end
                    S_DROP: begin
                        if (cfg_axis_tlast) begin
                            r_err      <= r_drop_err;
                            r_drop_err <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= '0;
        end else if (r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign cfg_axis_tready = r_tready;
    assign tbl_ena         = r_ena;
    assign tbl_wea         = r_wea;
    assign tbl_addra       = r_addra;
    assign tbl_dina        = r_dina;
    assign cfg_done        = r_done;
    assign cfg_err         = r_err;
    assign entries_written = r_entries;
    assign err_count       = r_err_count;

endmodule
`default_nettype wire
